// File: rtl/matbi_dma_ctrl_seq_if.sv
// ============================================================================
// Module   : matbi_dma_ctrl_seq_if
// Brief    : Control-slave status, DMA parameter and command/done bundle
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface matbi_dma_ctrl_seq_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 32
);
  logic                  ap_start;
  logic                  ap_ready;
  logic                  ap_done;
  logic                  ap_idle;
  logic [LEN_WIDTH-1:0]  rdma_transfer_byte;
  logic [ADDR_WIDTH-1:0] rdma_mem_ptr;
  logic [LEN_WIDTH-1:0]  wdma_transfer_byte;
  logic [ADDR_WIDTH-1:0] wdma_mem_ptr;
  logic                  rdma_cmd_valid;
  logic                  rdma_cmd_ready;
  logic [ADDR_WIDTH-1:0] rdma_cmd_addr;
  logic [LEN_WIDTH-1:0]  rdma_cmd_len;
  logic                  wdma_cmd_valid;
  logic                  wdma_cmd_ready;
  logic [ADDR_WIDTH-1:0] wdma_cmd_addr;
  logic [LEN_WIDTH-1:0]  wdma_cmd_len;
  logic                  rdma_done;
  logic                  wdma_done;
  logic                  timeout_err;

  // Sequencer side
  modport master (
    input  ap_start, rdma_transfer_byte, rdma_mem_ptr, wdma_transfer_byte, wdma_mem_ptr,
    input  rdma_cmd_ready, wdma_cmd_ready, rdma_done, wdma_done,
    output ap_ready, ap_done, ap_idle,
    output rdma_cmd_valid, rdma_cmd_addr, rdma_cmd_len,
    output wdma_cmd_valid, wdma_cmd_addr, wdma_cmd_len,
    output timeout_err
  );

  // Control slave / DMA engine side
  modport slave (
    output ap_start, rdma_transfer_byte, rdma_mem_ptr, wdma_transfer_byte, wdma_mem_ptr,
    output rdma_cmd_ready, wdma_cmd_ready, rdma_done, wdma_done,
    input  ap_ready, ap_done, ap_idle,
    input  rdma_cmd_valid, rdma_cmd_addr, rdma_cmd_len,
    input  wdma_cmd_valid, wdma_cmd_addr, wdma_cmd_len,
    input  timeout_err
  );
endinterface

`default_nettype wire

// File: rtl/matbi_dma_ctrl_seq.sv
// ============================================================================
// Module   : matbi_dma_ctrl_seq
// Brief    : Run sequencer issuing one read and one write DMA command per start
// Options  : define MATBI_DMA_CTRL_TIMEOUT_EN to build the run watchdog
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module matbi_dma_ctrl_seq #(
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 32,
  parameter int TIMEOUT_W  = 24
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  matbi_dma_ctrl_seq_if.master  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;

  logic                  r_ap_ready;
  logic [ADDR_WIDTH-1:0] r_rd_addr;
  logic [LEN_WIDTH-1:0]  r_rd_len;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [LEN_WIDTH-1:0]  r_wr_len;
  logic                  r_rd_valid;
  logic                  r_wr_valid;
  logic                  r_rd_issued;
  logic                  r_wr_issued;
  logic                  r_rd_done;
  logic                  r_wr_done;

  logic                  w_start;
  logic                  w_active;
  logic                  w_rd_fire;
  logic                  w_wr_fire;
  logic                  w_rd_done_set;
  logic                  w_wr_done_set;
  logic                  w_all_done;
  logic                  w_timeout;
  logic                  w_to_abort;

  assign w_start    = (r_state == S_IDLE) && bus.ap_start;
  assign w_active   = (r_state == S_ISSUE) || (r_state == S_WAIT);
  assign w_rd_fire  = r_rd_valid && bus.rdma_cmd_ready;
  assign w_wr_fire  = r_wr_valid && bus.wdma_cmd_ready;
  assign w_all_done = r_rd_done && r_wr_done;

  // A done pulse counts once its command has handshaken, including the handshake cycle itself
  assign w_rd_done_set = w_active && bus.rdma_done && (r_rd_issued || w_rd_fire);
  assign w_wr_done_set = w_active && bus.wdma_done && (r_wr_issued || w_wr_fire);

  // Normal completion in WAIT wins over a watchdog expiry in the same cycle
  assign w_to_abort = w_timeout && !((r_state == S_WAIT) && w_all_done);

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (w_to_abort) begin
          w_state_nxt = S_DONE;
        end else if (r_rd_issued && r_wr_issued) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (w_all_done || w_to_abort) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_ap_ready  <= 1'b0;
      r_rd_addr   <= '0;
      r_rd_len    <= '0;
      r_wr_addr   <= '0;
      r_wr_len    <= '0;
      r_rd_valid  <= 1'b0;
      r_wr_valid  <= 1'b0;
      r_rd_issued <= 1'b0;
      r_wr_issued <= 1'b0;
      r_rd_done   <= 1'b0;
      r_wr_done   <= 1'b0;
    end else begin
      r_ap_ready <= w_start;
      if (w_start) begin
        // Zero-length channels are treated as already issued and completed
        r_rd_addr   <= bus.rdma_mem_ptr;
        r_rd_len    <= bus.rdma_transfer_byte;
        r_wr_addr   <= bus.wdma_mem_ptr;
        r_wr_len    <= bus.wdma_transfer_byte;
        r_rd_valid  <= (bus.rdma_transfer_byte != '0);
        r_wr_valid  <= (bus.wdma_transfer_byte != '0);
        r_rd_issued <= (bus.rdma_transfer_byte == '0);
        r_wr_issued <= (bus.wdma_transfer_byte == '0);
        r_rd_done   <= (bus.rdma_transfer_byte == '0);
        r_wr_done   <= (bus.wdma_transfer_byte == '0);
      end else begin
        if (w_rd_fire) begin
          r_rd_valid  <= 1'b0;
          r_rd_issued <= 1'b1;
        end
        if (w_wr_fire) begin
          r_wr_valid  <= 1'b0;
          r_wr_issued <= 1'b1;
        end
        if (w_rd_done_set) begin
          r_rd_done <= 1'b1;
        end
        if (w_wr_done_set) begin
          r_wr_done <= 1'b1;
        end
        if (w_to_abort) begin
          r_rd_valid <= 1'b0;
          r_wr_valid <= 1'b0;
        end
      end
    end
  end

`ifdef MATBI_DMA_CTRL_TIMEOUT_EN
  // Abort is decided one count early so DONE lands on the cycle the counter hits all-ones
  localparam logic [TIMEOUT_W-1:0] c_TO_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

  logic [TIMEOUT_W-1:0] r_to_cnt;
  logic                 r_timeout_err;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_to_cnt      <= '0;
      r_timeout_err <= 1'b0;
    end else if (w_start) begin
      r_to_cnt      <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if (w_active) begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end
      if (w_to_abort) begin
        r_timeout_err <= 1'b1;
      end
    end
  end

  assign w_timeout       = w_active && (r_to_cnt == c_TO_LAST);
  assign bus.timeout_err = r_timeout_err;
`else
  assign w_timeout = 1'b0;

  // TIMEOUT_W only sizes the watchdog, which is absent in this build
  if (TIMEOUT_W > 0) begin : g_no_watchdog
    assign bus.timeout_err = 1'b0;
  end
`endif

  assign bus.ap_ready       = r_ap_ready;
  assign bus.ap_done        = (r_state == S_DONE);
  assign bus.ap_idle        = (r_state == S_IDLE);
  assign bus.rdma_cmd_valid = r_rd_valid;
  assign bus.rdma_cmd_addr  = r_rd_addr;
  assign bus.rdma_cmd_len   = r_rd_len;
  assign bus.wdma_cmd_valid = r_wr_valid;
  assign bus.wdma_cmd_addr  = r_wr_addr;
  assign bus.wdma_cmd_len   = r_wr_len;

endmodule

`default_nettype wire
